// File: rtl/pixel_write_queue_if.sv
// Pixel program port (copy engine side) and SRAM write slot (controller side)
// bundled together; the queue sits in between as the slave.
interface pixel_write_queue_if;
    logic [9:0]  program_x;
    logic [9:0]  program_y;
    logic [15:0] program_data;
    logic        program_write;
    logic        program_ready;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;

    modport master (
        output program_x, program_y, program_data, program_write, wr_ready,
        input  program_ready, wr_addr, wr_data, wr_valid
    );

    modport slave (
        input  program_x, program_y, program_data, program_write, wr_ready,
        output program_ready, wr_addr, wr_data, wr_valid
    );
endinterface

// File: rtl/pixel_write_queue.sv
// Converts copy-engine pixel beats to linear SRAM word addresses and queues them
// in a show-ahead FIFO for the SRAM controller's write slot, with backpressure.
module pixel_write_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480
) (
    input  logic                         clk,
    input  logic                         reset_n,
    pixel_write_queue_if.slave           bus,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         clip_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_inrange_q, s1_inrange_d;
    logic [19:0]      s1_addr_q;
    logic [15:0]      s1_data_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             clip_err_q, clip_err_d;
    logic             written_q, written_d;
    logic [35:0]      mem [DEPTH];

    logic             accept, push, pop, in_range;
    logic [19:0]      addr_calc, y_ext;
    logic [LVL_W:0]   occupied;

    // The stage-1 slot counts toward occupancy so a push can never hit a full FIFO.
    assign occupied          = {1'b0, level_q} + {{LVL_W{1'b0}}, s1_valid_q};
    assign bus.program_ready = !flush && (occupied < (LVL_W+1)'(DEPTH));

    assign accept    = bus.program_write && bus.program_ready;
    assign y_ext     = {10'b0, bus.program_y};
    assign addr_calc = (y_ext << 9) + (y_ext << 7) + {10'b0, bus.program_x};
    assign in_range  = (32'(bus.program_x) < H_RES) && (32'(bus.program_y) < V_RES);

    assign push = s1_valid_q && s1_inrange_q && !flush;
    assign pop  = bus.wr_valid && bus.wr_ready && !flush;

    always_comb begin
        s1_valid_d   = accept;
        s1_inrange_d = in_range;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q + LVL_W'(push) - LVL_W'(pop);
        clip_err_d   = clip_err_q | (s1_valid_q && !s1_inrange_q && !flush);
        written_d    = written_q | push;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_inrange_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            clip_err_q   <= 1'b0;
            written_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_inrange_q <= s1_inrange_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            clip_err_q   <= clip_err_d;
            written_q    <= written_d;
        end
    end

    // Datapath storage carries no reset; validity comes from the control state.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_addr_q <= addr_calc;
            s1_data_q <= bus.program_data;
        end
        if (push) mem[wr_ptr_q] <= {s1_addr_q, s1_data_q};
    end

    // Outputs read zero until the storage has been written since reset.
    assign bus.wr_valid = (level_q != '0);
    assign bus.wr_addr  = written_q ? mem[rd_ptr_q][35:16] : 20'd0;
    assign bus.wr_data  = written_q ? mem[rd_ptr_q][15:0]  : 16'd0;
    assign level        = level_q;
    assign clip_err     = clip_err_q;
endmodule

// File: doc/pixel_write_queue.md
# pixel_write_queue

Receiving end of the copy engine's pixel program port. The block accepts `program_x`/`program_y`/`program_data`/`program_write` beats from the copy engine inside `boxhead_soc`. It converts each beat into a linear frame-buffer address, buffers the result in a FIFO, and presents it as a write request to the SRAM controller's write slot, which the controller grants around VGA fetches. It gives the copy engine backpressure, so no pixel is lost while the SRAM is busy serving the display.

## Interface
- `DEPTH`, 16: FIFO entries; a power of two, at least 4.
- `H_RES`, 640: visible width in pixels; the address stride per row.
- `V_RES`, 480: visible height in pixels.
- `clk`  in  1: system clock (CLOCK_50 domain).
- `reset_n`  in  1: reset, asynchronous assert, active-low.
- `program_x`  in  10: pixel column.
- `program_y`  in  10: pixel row.
- `program_data`  in  16: RGB565 pixel value.
- `program_write`  in  1: beat valid.
- `program_ready`  out  1: the block can accept a beat this cycle.
- `flush`  in  1: synchronous clear of the pipeline and FIFO.
- `wr_addr`  out  20: SRAM word address of the head entry.
- `wr_data`  out  16: pixel value of the head entry.
- `wr_valid`  out  1: the FIFO is non-empty.
- `wr_ready`  in  1: the SRAM controller consumes the head entry this cycle.
- `level`  out  $clog2(DEPTH+1): number of FIFO entries occupied.
- `clip_err`  out  1: sticky flag, set when an out-of-range beat has been dropped.

## Operation
- **Accept.** A beat is accepted on a rising edge where `program_write && program_ready`.
- **Stage 1 (address stage).**
  - Registers x, y and data, sets `s1_valid`, and computes `addr = (y<<9) + (y<<7) + x`, which equals y*640+x.
  - The address is 20 bits with no overflow for in-range coordinates; the maximum is 307199.
- **Range check.** A beat with x ≥ H_RES or y ≥ V_RES is accepted but never enters the FIFO. Its `s1_valid` is cleared and `clip_err` is set.
- **Stage 2 (FIFO push).** A valid stage-1 entry is written into the FIFO at `wr_ptr` on the next edge.
- **Output.**
  - The FIFO is show-ahead: `wr_addr`/`wr_data` always reflect the entry at `rd_ptr`.
  - A pop happens on an edge where `wr_valid && wr_ready`. `wr_ready` is ignored while `wr_valid` = 0.
- **Backpressure.** `program_ready = (level + s1_valid) < DEPTH`. The stage-1 entry is reserved in advance, so a push into a full FIFO can never occur.
- **Simultaneous push and pop.** `level` is unchanged and both pointers advance.
- **Pointers.** Each pointer is $clog2(DEPTH) bits and wraps modulo DEPTH.
- **Flush.** `flush` = 1 clears the pointers, `level` and `s1_valid`, and ignores any beat or pop in the same cycle. `program_ready` = 0 during that cycle. `clip_err` is not cleared.
- **Reset.** Reset asserted mid-operation discards all buffered pixels immediately.

## Timing
- **Reset values.** `program_ready` = 1, `wr_valid` = 0, `level` = 0, `clip_err` = 0, `wr_addr` = 0, `wr_data` = 0. The FIFO storage itself is not reset, but the outputs read 0 until the first write.
- **Latency.** A beat accepted at edge N gives `wr_valid` = 1 after edge N+1, with `wr_addr`/`wr_data` valid in that same cycle.
- **Throughput.** One beat per cycle in and one pop per cycle out, sustained.
- **`program_ready`.** Combinational from registered state only (`level`, `s1_valid`, `flush`). It has no path from `program_write`.
- **`level`.** Counts only FIFO entries, not the stage-1 entry. It updates on the edge of each push or pop.
- **`clip_err`.** Set on the edge that stage 1 drops the beat, that is, one cycle after acceptance.

## Test plan
1. **Single beat.** Reset; send one beat x=3, y=2, data=16'hDE79 with `wr_ready` = 0 → after 2 edges `wr_valid` = 1, `wr_addr` = 1283, `wr_data` = 16'hDE79, `level` = 1. Then assert `wr_ready` for one cycle → `wr_valid` = 0, `level` = 0.
2. **Fill to capacity.** Hold `wr_ready` = 0 and stream 20 beats with x = 0..19, y = 0 → `program_ready` falls after 16 accepted beats and `level` stays at 16. Then drain with `wr_ready` = 1 → addresses 0..15 appear in order with no gaps, and the remaining 4 beats are then accepted.
3. **Sustained streaming.** Stream 100 beats with `wr_ready` constantly 1 → `program_ready` never deasserts, `level` ≤ 1, and the pop sequence matches the push sequence, including across pointer wrap. Include the corner beat x=639, y=479 → `wr_addr` = 307199.
4. **Out of range.** Send beats x=640, y=0 and then x=0, y=480 → neither appears on `wr_valid`, and `clip_err` = 1 and stays set. A following in-range beat passes normally.
5. **Flush and reset mid-stream.**
   - With 8 entries queued, pulse `flush` → next cycle `level` = 0, `wr_valid` = 0, and `clip_err` is unchanged.
   - With entries queued, drop `reset_n` asynchronously mid-cycle → outputs go to their reset values before the next clock edge.
